// File: rtl/seg7_sequence_checker_pkg.sv
// Shared segment patterns and FSM encoding for the seven-segment sequence checker.
// Segment bits are active-low, ordered a..g from bit 6 down to bit 0.
package seg7_sequence_checker_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic {
      IDLE  = 1'b0,
      TRACK = 1'b1
   } state_t;

endpackage

// File: rtl/seg7_sequence_checker_if.sv
// Segment bus plus counter controls in, decoded digit and check status out.
// The master side is whatever drives the display path; the checker is the slave.
interface seg7_sequence_checker_if #(
   parameter int WIDTH = 7,
   parameter int ERR_W = 8
);

   logic [WIDTH-1:0] seg_in;
   logic             up_down;
   logic             pause;
   logic [3:0]       digit_out;
   logic             digit_valid;
   logic             locked;
   logic             seq_error;
   logic [ERR_W-1:0] err_count;

   modport master (
      output seg_in, up_down, pause,
      input  digit_out, digit_valid, locked, seq_error, err_count
   );

   modport slave (
      input  seg_in, up_down, pause,
      output digit_out, digit_valid, locked, seq_error, err_count
   );

endinterface

// File: rtl/seg7_sequence_checker_seg7_to_bin.sv
// Combinational inverse of the seven-segment decoder table.
// Digits at or above the counter modulus are reported as not legal.
module seg7_to_bin
   import seg7_sequence_checker_pkg::*;
#(
   parameter int N     = 10,
   parameter int WIDTH = 7
) (
   input  logic [WIDTH-1:0] seg,
   output logic [3:0]       digit,
   output logic             is_blank,
   output logic             is_legal
);

   localparam logic [4:0] DIG_LIMIT = 5'(N);

   logic hit;

   always_comb begin
      digit = 4'd0;
      hit   = 1'b1;
      case (seg)
         SEG_0:   digit = 4'd0;
         SEG_1:   digit = 4'd1;
         SEG_2:   digit = 4'd2;
         SEG_3:   digit = 4'd3;
         SEG_4:   digit = 4'd4;
         SEG_5:   digit = 4'd5;
         SEG_6:   digit = 4'd6;
         SEG_7:   digit = 4'd7;
         SEG_8:   digit = 4'd8;
         SEG_9:   digit = 4'd9;
         default: hit   = 1'b0;
      endcase
   end

   assign is_blank = (seg == SEG_BLANK);
   assign is_legal = hit && ({1'b0, digit} < DIG_LIMIT);

endmodule

// File: rtl/seg7_sequence_checker.sv
// Samples the counter's segment bus, decodes it and checks each digit against the
// value predicted from the previous digit and the one-edge-delayed pause/up_down.
module seg7_sequence_checker
   import seg7_sequence_checker_pkg::*;
#(
   parameter int N     = 10,
   parameter int WIDTH = 7,
   parameter int ERR_W = 8
) (
   input logic                    Clock_slow,
   input logic                    reset,
   seg7_sequence_checker_if.slave bus
);

   localparam logic [3:0] LAST = 4'(N - 1);

   // Next count value given the controls that were live when the counter stepped.
   function automatic logic [3:0] predict(input logic [3:0] prev,
                                          input logic       up,
                                          input logic       hold);
      logic [3:0] nxt;
      if (hold)
         nxt = prev;
      else if (up)
         nxt = (prev == LAST) ? 4'd0 : prev + 4'd1;
      else
         nxt = (prev == 4'd0) ? LAST : prev - 4'd1;
      return nxt;
   endfunction

   logic [3:0] dec_digit;
   logic       dec_blank;
   logic       dec_legal;

   seg7_to_bin #(
      .N     (N),
      .WIDTH (WIDTH)
   ) u_decode (
      .seg      (bus.seg_in),
      .digit    (dec_digit),
      .is_blank (dec_blank),
      .is_legal (dec_legal)
   );

   state_t           state_q,   state_d;
   logic [3:0]       prev_q,    prev_d;
   logic             up_dly_q,  up_dly_d;
   logic             pause_dly_q, pause_dly_d;
   logic [3:0]       digit_q,   digit_d;
   logic             valid_q,   valid_d;
   logic             err_q,     err_d;
   logic [ERR_W-1:0] cnt_q,     cnt_d;
   logic [3:0]       expected;

   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      digit_d     = digit_q;
      valid_d     = dec_legal;
      err_d       = 1'b0;
      up_dly_d    = bus.up_down;
      pause_dly_d = bus.pause;
      expected    = predict(prev_q, up_dly_q, pause_dly_q);

      case (state_q)
         IDLE: begin
            if (dec_legal) begin
               prev_d  = dec_digit;
               state_d = TRACK;
            end else if (!dec_blank) begin
               err_d = 1'b1;
            end
         end
         TRACK: begin
            if (dec_legal) begin
               // A wrong digit is flagged but still adopted so tracking resyncs.
               prev_d = dec_digit;
               err_d  = (dec_digit != expected);
            end else begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (dec_legal)
         digit_d = dec_digit;

      cnt_d = cnt_q;
      if (err_d && (cnt_q != {ERR_W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge Clock_slow or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         prev_q      <= 4'd0;
         up_dly_q    <= 1'b1;
         pause_dly_q <= 1'b0;
         digit_q     <= 4'd0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         up_dly_q    <= up_dly_d;
         pause_dly_q <= pause_dly_d;
         digit_q     <= digit_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.digit_out   = digit_q;
   assign bus.digit_valid = valid_q;
   assign bus.locked      = (state_q == TRACK);
   assign bus.seq_error   = err_q;
   assign bus.err_count   = cnt_q;

endmodule

// File: tb/tb_seg7_sequence_checker.sv
// Scoreboard bench for seg7_sequence_checker: each sample pushes its expected
// outputs, the observed outputs one edge later are queued and compared per test.
module tb_seg7_sequence_checker;

   localparam int N     = 10;
   localparam int WIDTH = 7;
   localparam int ERR_W = 8;

   localparam logic [6:0] P_BLANK   = 7'b1111111;
   localparam logic [6:0] P_ILLEGAL = 7'b1111110;

   logic Clock_slow = 1'b0;
   logic reset;

   always #5 Clock_slow = ~Clock_slow;

   seg7_sequence_checker_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) bus ();

   seg7_sequence_checker #(.N(N), .WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
      .Clock_slow (Clock_slow),
      .reset      (reset),
      .bus        (bus)
   );

   typedef struct packed {
      logic [3:0]       d;
      logic             v;
      logic             l;
      logic             e;
      logic [ERR_W-1:0] c;
   } obs_t;

   obs_t exp_q[$];
   obs_t got_q[$];
   int   total = 0;
   int   bad   = 0;

   logic [6:0] tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

   logic             m_trk;
   logic [3:0]       m_prev;
   logic [3:0]       m_dig;
   logic             m_up;
   logic             m_ps;
   logic [ERR_W-1:0] m_cnt;

   task automatic model_reset();
      m_trk  = 1'b0;
      m_prev = 4'd0;
      m_dig  = 4'd0;
      m_up   = 1'b1;
      m_ps   = 1'b0;
      m_cnt  = '0;
   endtask

   // One sample: drive at the falling edge, predict, then capture after the rising edge.
   task automatic drive(input logic [6:0] seg, input logic ud, input logic ps);
      obs_t       e, g;
      logic       legal, blank, err;
      logic [3:0] dg, pr;
      @(negedge Clock_slow);
      bus.seg_in  = seg;
      bus.up_down = ud;
      bus.pause   = ps;
      legal = 1'b0;
      dg    = 4'd0;
      blank = (seg == P_BLANK);
      for (int i = 0; i < N; i++)
         if (tab[i] == seg) begin
            legal = 1'b1;
            dg    = 4'(i);
         end
      if (m_ps)      pr = m_prev;
      else if (m_up) pr = (m_prev == 4'(N-1)) ? 4'd0 : m_prev + 4'd1;
      else           pr = (m_prev == 4'd0) ? 4'(N-1) : m_prev - 4'd1;
      err = 1'b0;
      if (!m_trk) begin
         if (legal) begin
            m_prev = dg;
            m_trk  = 1'b1;
         end else if (!blank) err = 1'b1;
      end else if (legal) begin
         err    = (dg != pr);
         m_prev = dg;
      end else begin
         err   = 1'b1;
         m_trk = 1'b0;
      end
      if (legal) m_dig = dg;
      if (err && m_cnt != {ERR_W{1'b1}}) m_cnt = m_cnt + 1'b1;
      m_up = ud;
      m_ps = ps;
      e.d = m_dig; e.v = legal; e.l = m_trk; e.e = err; e.c = m_cnt;
      exp_q.push_back(e);
      @(posedge Clock_slow);
      #1;
      g.d = bus.digit_out; g.v = bus.digit_valid; g.l = bus.locked;
      g.e = bus.seq_error; g.c = bus.err_count;
      got_q.push_back(g);
   endtask

   task automatic test_reset();
      reset       = 1'b0;
      bus.seg_in  = P_BLANK;
      bus.up_down = 1'b1;
      bus.pause   = 1'b0;
      model_reset();
      #3;
      total++;
      if ({bus.digit_out, bus.digit_valid, bus.locked, bus.seq_error, bus.err_count} !== '0) begin
         bad++;
         $display("FAIL reset_state got d=%0d v=%b l=%b e=%b c=%0d want all zero",
                  bus.digit_out, bus.digit_valid, bus.locked, bus.seq_error, bus.err_count);
      end
      repeat (2) @(posedge Clock_slow);
      @(negedge Clock_slow);
      reset = 1'b1;
   endtask

   task automatic test_up_count();
      obs_t e, g;
      int   k = 0;
      for (int i = 0; i < 12; i++) drive(tab[i % 10], 1'b1, 1'b0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); total++;
         if (g !== e) begin
            bad++;
            $display("FAIL up_count[%0d] got d=%0d v=%b l=%b e=%b c=%0d want d=%0d v=%b l=%b e=%b c=%0d",
                     k, g.d, g.v, g.l, g.e, g.c, e.d, e.v, e.l, e.e, e.c);
         end
         k++;
      end
   endtask

   task automatic test_direction();
      obs_t e, g;
      int   k = 0;
      drive(tab[2], 1'b0, 1'b0);
      drive(tab[1], 1'b0, 1'b0);
      drive(tab[0], 1'b0, 1'b0);
      drive(tab[9], 1'b0, 1'b0);
      drive(tab[8], 1'b0, 1'b0);
      drive(tab[7], 1'b1, 1'b0);
      drive(tab[8], 1'b1, 1'b0);
      drive(tab[9], 1'b1, 1'b0);
      drive(tab[0], 1'b0, 1'b0);
      drive(tab[9], 1'b1, 1'b0);
      drive(tab[0], 1'b1, 1'b0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); total++;
         if (g !== e) begin
            bad++;
            $display("FAIL direction[%0d] got d=%0d v=%b l=%b e=%b c=%0d want d=%0d v=%b l=%b e=%b c=%0d",
                     k, g.d, g.v, g.l, g.e, g.c, e.d, e.v, e.l, e.e, e.c);
         end
         k++;
      end
      total++;
      if (bus.err_count !== 8'd0) begin
         bad++;
         $display("FAIL direction_errcount got %0d want 0", bus.err_count);
      end
   endtask

   task automatic test_pause();
      obs_t e, g;
      int   k = 0;
      int   pulses = 0;
      for (int i = 1; i <= 4; i++) drive(tab[i], 1'b1, 1'b0);
      repeat (3) drive(tab[5], 1'b1, 1'b1);
      drive(tab[5], 1'b1, 1'b0);
      drive(tab[6], 1'b1, 1'b1);
      drive(tab[7], 1'b1, 1'b0);
      drive(tab[8], 1'b1, 1'b0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); total++;
         if (g.e) pulses++;
         if (g !== e) begin
            bad++;
            $display("FAIL pause[%0d] got d=%0d v=%b l=%b e=%b c=%0d want d=%0d v=%b l=%b e=%b c=%0d",
                     k, g.d, g.v, g.l, g.e, g.c, e.d, e.v, e.l, e.e, e.c);
         end
         k++;
      end
      total++;
      if (pulses != 1 || bus.err_count !== 8'd1) begin
         bad++;
         $display("FAIL pause_single_error got pulses=%0d count=%0d want pulses=1 count=1",
                  pulses, bus.err_count);
      end
   endtask

   task automatic test_illegal();
      obs_t e, g;
      int   k = 0;
      drive(P_ILLEGAL, 1'b1, 1'b0);
      total++;
      if (bus.digit_out !== 4'd8 || bus.locked !== 1'b0 || bus.seq_error !== 1'b1) begin
         bad++;
         $display("FAIL illegal_hold got d=%0d l=%b e=%b want d=8 l=0 e=1",
                  bus.digit_out, bus.locked, bus.seq_error);
      end
      drive(P_BLANK, 1'b1, 1'b0);
      drive(P_ILLEGAL, 1'b1, 1'b0);
      drive(tab[3], 1'b1, 1'b0);
      drive(tab[4], 1'b1, 1'b0);
      drive(tab[0], 1'b1, 1'b0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); total++;
         if (g !== e) begin
            bad++;
            $display("FAIL illegal[%0d] got d=%0d v=%b l=%b e=%b c=%0d want d=%0d v=%b l=%b e=%b c=%0d",
                     k, g.d, g.v, g.l, g.e, g.c, e.d, e.v, e.l, e.e, e.c);
         end
         k++;
      end
   endtask

   task automatic test_mid_reset();
      obs_t e, g;
      int   k = 0;
      total++;
      if (bus.err_count !== 8'd4 || bus.locked !== 1'b1) begin
         bad++;
         $display("FAIL mid_reset_setup got c=%0d l=%b want c=4 l=1", bus.err_count, bus.locked);
      end
      @(posedge Clock_slow);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      total++;
      if ({bus.digit_out, bus.digit_valid, bus.locked, bus.seq_error, bus.err_count} !== '0) begin
         bad++;
         $display("FAIL mid_reset_async got d=%0d v=%b l=%b e=%b c=%0d want all zero",
                  bus.digit_out, bus.digit_valid, bus.locked, bus.seq_error, bus.err_count);
      end
      bus.seg_in = P_BLANK; bus.up_down = 1'b1; bus.pause = 1'b0;
      @(negedge Clock_slow);
      reset = 1'b1;
      drive(tab[7], 1'b1, 1'b0);
      drive(tab[8], 1'b1, 1'b0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); total++;
         if (g !== e) begin
            bad++;
            $display("FAIL mid_reset[%0d] got d=%0d v=%b l=%b e=%b c=%0d want d=%0d v=%b l=%b e=%b c=%0d",
                     k, g.d, g.v, g.l, g.e, g.c, e.d, e.v, e.l, e.e, e.c);
         end
         k++;
      end
   endtask

   task automatic test_saturate();
      obs_t e, g;
      int   k = 0;
      repeat (300) drive(tab[0], 1'b1, 1'b0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); total++;
         if (g !== e) begin
            bad++;
            $display("FAIL saturate[%0d] got d=%0d v=%b l=%b e=%b c=%0d want d=%0d v=%b l=%b e=%b c=%0d",
                     k, g.d, g.v, g.l, g.e, g.c, e.d, e.v, e.l, e.e, e.c);
         end
         k++;
      end
      total++;
      if (bus.err_count !== 8'd255) begin
         bad++;
         $display("FAIL saturate_final got %0d want 255", bus.err_count);
      end
   endtask

   initial begin
      test_reset();
      test_up_count();
      test_direction();
      test_pause();
      test_illegal();
      test_mid_reset();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg7_sequence_checker.md
Name: seg7_sequence_checker

Overview:
- Inverse end of the counter-to-display path. Samples the 7-bit active-low segment bus driven by the up/down counter's seven-segment decoder.
- Decodes each segment pattern back to a binary digit and tracks the count sequence.
- Checks each sample against the value predicted from the previous sample and the pause/up_down controls.
- Flags, counts, and resynchronises on mismatches. Used as on-board self-check and as the bench scoreboard front end.

Parameters:
N, 10, counter modulus; legal digits 0..N-1 (N <= 10).
WIDTH, 7, segment bus width.
ERR_W, 8, width of saturating error counter.

Ports:
Clock_slow  input  1  checker clock, same divided clock that steps the counter; rising-edge.
reset  input  1  asynchronous, active-low; clears all state.
seg_in  input  WIDTH  active-low segments, bit6=a .. bit0=g.
up_down  input  1  counter direction control (1=up).
pause  input  1  counter hold control.
digit_out  output  4  last decoded digit.
digit_valid  output  1  seg_in held a legal digit pattern at last edge.
locked  output  1  FSM in TRACK.
seq_error  output  1  one-cycle pulse on mismatch or illegal pattern.
err_count  output  ERR_W  saturating count of seq_error pulses.

Behaviour:
- Reset asserted (reset=0), at any time including mid-sequence:
  - digit_out=0, digit_valid=0, locked=0, seq_error=0, err_count=0.
  - FSM=IDLE; prev=0; up_d=1; pause_d=0.
- Decode table (seg_in -> digit):
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9.
  - 1111111 is BLANK. Any other pattern is ILLEGAL.
  - A legal pattern whose digit >= N is treated as ILLEGAL.
- Latency: digit_out, digit_valid, seq_error and locked all update at the same rising Clock_slow edge at which seg_in is sampled, i.e. 1 cycle, all registered.
- digit_out holds its last legal value when the current sample is BLANK or ILLEGAL.
- Control alignment:
  - The counter updates at edge k-1; its segment output is sampled at edge k.
  - up_down and pause are therefore registered (up_d, pause_d) at every edge.
  - The prediction at edge k uses prev, up_d and pause_d, all captured at edge k-1.
- Prediction exp(prev):
  - pause_d=1 -> prev.
  - up_d=1 -> (prev==N-1) ? 0 : prev+1.
  - up_d=0 -> (prev==0) ? N-1 : prev-1.
  - Arithmetic is 4-bit modulo N; no other wrap points.
- FSM states:
  - IDLE:
    - legal digit -> prev<=digit, go TRACK, seq_error=0.
    - BLANK -> stay IDLE, no error.
    - ILLEGAL -> stay IDLE, seq_error=1.
  - TRACK:
    - legal digit == exp -> prev<=digit, stay TRACK.
    - legal digit != exp -> seq_error=1, prev<=digit (resync), stay TRACK.
    - BLANK or ILLEGAL -> seq_error=1, go IDLE.
- err_count: increments on each seq_error pulse and saturates at all-ones; it never wraps.
- A direction change takes effect exactly one sample later, through up_d. A reversal at the wrap digit (0 or N-1) is not an error.
- locked = (state==TRACK), registered.

Decomposition:
- Shared package:
  - segment pattern constants SEG_0..SEG_9 and SEG_BLANK.
  - FSM state encoding IDLE/TRACK.
- Sub-module seg7_to_bin: combinational inverse of the segment table. Outputs digit[3:0], is_blank and is_legal (is_legal includes the digit<N check). Instantiated once.
- Checker FSM, prediction, control-delay and error counter live in the top.

Test Plan:
- Reset release, seg_in=SEG_0, up_down=1, pause=0, feed 0,1,..,9,0,1 -> locked=1 from first edge; digit_out follows each sample; seq_error never asserts; err_count=0.
- Down count 2,1,0,9,8 with up_down=0 -> wrap 0->9 accepted; no seq_error.
- pause=1 for 3 edges while holding 5, then resume up -> 5,5,5,5,6 accepted; injected 7 after 6 -> exactly one seq_error pulse, err_count=1, next expected value is 8.
- seg_in=1111110 (ILLEGAL) while in TRACK -> seq_error pulse, locked=0, digit_out keeps its last value; next legal digit relocks with no error. BLANK in IDLE -> no error.
- Force 300 mismatches with ERR_W=8 -> err_count saturates at 255.
- Assert reset mid-TRACK with err_count=4 -> all outputs 0 immediately without a clock edge; FSM returns to IDLE.
